// File: rtl/dmem_pkg.sv
// Shared constants and address-region decode for the data-memory responder.
package dmem_pkg;

    localparam logic [11:0] OFF_GPIO   = 12'h000;
    localparam logic [11:0] OFF_CYCLE  = 12'h004;
    localparam logic [11:0] OFF_TCMP   = 12'h008;
    localparam logic [11:0] OFF_STATUS = 12'h00C;

    localparam logic [31:0] MMIO_BASE_DFLT = 32'h0000_1000;

    localparam logic [7:0]  GPIO_RST = 8'h00;
    localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    // RAM takes priority so a large RAM overlapping the MMIO page still behaves as RAM.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [19:0] page);
        if (addr < ram_bytes) begin
            return REG_RAM;
        end else if (addr[31:12] == page) begin
            return REG_MMIO;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running cycle counter plus optional compare/flag timer.
// Compare and flag logic exist only when DMEM_TIMER_EN is defined.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmp_we_i,
    input  logic        st_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] cycle_o,
    output logic [31:0] cmp_o,
    output logic        flag_o
);

    logic [31:0] cycle_q, cycle_d;

    assign cycle_d = cycle_q + 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_o = cycle_q;

`ifdef DMEM_TIMER_EN
    logic [31:0] cmp_q, cmp_d;
    logic        flag_q, flag_d;

    // Match uses the pre-write compare value; a match overrides a same-edge W1C.
    always_comb begin
        cmp_d  = cmp_q;
        flag_d = flag_q;
        if (cmp_we_i) begin
            cmp_d = wdata_i;
        end
        if (st_we_i && wdata_i[0]) begin
            flag_d = 1'b0;
        end
        if (cycle_q == cmp_q) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_q  <= TCMP_RST;
            flag_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            flag_q <= flag_d;
        end
    end

    assign cmp_o  = cmp_q;
    assign flag_o = flag_q;
`else
    logic unused_timer_in;
    assign unused_timer_in = ^{cmp_we_i, st_we_i, wdata_i};
    assign cmp_o  = '0;
    assign flag_o = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, GPIO register and timer MMIO page with combinational reads.
// Build with DMEM_TIMER_EN defined to enable TIMER_CMP, STATUS and timer_irq.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [9:0]  W_GPIO    = OFF_GPIO[11:2];
    localparam logic [9:0]  W_CYCLE   = OFF_CYCLE[11:2];
    localparam logic [9:0]  W_TCMP    = OFF_TCMP[11:2];
    localparam logic [9:0]  W_STATUS  = OFF_STATUS[11:2];

    region_e     region;
    logic [AW-1:0] word_idx;
    logic [9:0]  off_word;
    logic        ram_we, gpio_we, cmp_we, st_we;
    logic [7:0]  gpio_q, gpio_d;
    logic [31:0] cycle, cmp;
    logic        flag;
    logic [31:0] mem_q [DEPTH_WORDS];
    logic        unused_addr_lsb;

    assign region   = decode_region(alu_result, RAM_BYTES, MMIO_BASE[31:12]);
    assign word_idx = alu_result[AW+1:2];
    assign off_word = alu_result[11:2];
    assign unused_addr_lsb = ^alu_result[1:0];

    assign ram_we  = mem_write && (region == REG_RAM);
    assign gpio_we = mem_write && (region == REG_MMIO) && (off_word == W_GPIO);
    assign cmp_we  = mem_write && (region == REG_MMIO) && (off_word == W_TCMP);
    assign st_we   = mem_write && (region == REG_MMIO) && (off_word == W_STATUS);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[word_idx] <= write_data;
        end
    end

    assign gpio_d = gpio_we ? write_data[7:0] : gpio_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q <= GPIO_RST;
        end else begin
            gpio_q <= gpio_d;
        end
    end

    mmio_timer u_timer (
        .clk_i    (clk),
        .rst_ni   (reset),
        .cmp_we_i (cmp_we),
        .st_we_i  (st_we),
        .wdata_i  (write_data),
        .cycle_o  (cycle),
        .cmp_o    (cmp),
        .flag_o   (flag)
    );

    always_comb begin
        read_data = '0;
        case (region)
            REG_RAM: read_data = mem_q[word_idx];
            REG_MMIO: begin
                case (off_word)
                    W_GPIO:   read_data = {24'b0, gpio_q};
                    W_CYCLE:  read_data = cycle;
                    W_TCMP:   read_data = cmp;
                    W_STATUS: read_data = {31'b0, flag};
                    default:  read_data = '0;
                endcase
            end
            default: read_data = '0;
        endcase
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = flag;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder; expected reads are queued on stimulus and popped on sampling.
module tb_data_mem_responder;

`ifdef DMEM_TIMER_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int unsigned cyc_m = 0;
    int unsigned cyc_ofs = 0;

    data_mem_responder #(.DEPTH_WORDS(64), .MMIO_BASE(32'h0000_1000)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .alu_result (alu_result),
        .write_data (write_data),
        .read_data  (read_data),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: value seen during the current cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc_m <= 0;
        else        cyc_m <= cyc_m + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read in the current cycle without advancing.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] e);
        alu_result = a;
        exp_q.push_back(e);
        #1;
        chk(tag, read_data, exp_q.pop_front());
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        @(negedge clk);
        mem_write = 1'b0;
        peek(tag, a, e);
    endtask

    task automatic rd_cyc(input string tag);
        @(negedge clk);
        mem_write = 1'b0;
        peek(tag, 32'h0000_1004, 32'(cyc_m + cyc_ofs));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write  = 1'b1;
        alu_result = a;
        write_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_write = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] x;

        // Reset state
        @(negedge clk);
        chk("rst_gpio", {24'b0, gpio_out}, 32'h0);
        chk("rst_irq", {31'b0, timer_irq}, 32'h0);
        peek("rst_cycle", 32'h0000_1004, 32'h0);
        peek("rst_tcmp", 32'h0000_1008, TEN ? 32'hFFFF_FFFF : 32'h0);

        // Cycle counter from reset release
        @(negedge clk);
        reset = 1'b1;
        peek("cyc0", 32'h0000_1004, 32'd0);
        rd("cyc1", 32'h0000_1004, 32'd1);
        idle(8);
        rd("cyc10", 32'h0000_1004, 32'd10);
        wr(32'h0000_1004, 32'd5);
        rd_cyc("cyc_ro");

        // RAM write, read-during-write, byte-offset ignore
        wr(32'h0000_0010, 32'h1234_5678);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        peek("rdw_old", 32'h0000_0010, 32'h1234_5678);
        rd("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_00FC, 32'hCAFE_F00D);
        rd("ram_top", 32'h0000_00FC, 32'hCAFE_F00D);

        // GPIO
        wr(32'h0000_1000, 32'h0000_01A5);
        peek("gpio_rdw", 32'h0000_1000, 32'h0);
        rd("gpio_rd", 32'h0000_1000, 32'h0000_00A5);
        chk("gpio_out", {24'b0, gpio_out}, 32'h0000_00A5);
        rd("gpio_lsb", 32'h0000_1003, 32'h0000_00A5);

        // Unmapped and unlisted addresses
        wr(32'h0000_0800, 32'hBAD0_0001);
        wr(32'h0000_2000, 32'hBAD0_0077);
        wr(32'h0000_1010, 32'hBAD0_0003);
        rd("unmap_800", 32'h0000_0800, 32'h0);
        rd("unmap_2000", 32'h0000_2000, 32'h0);
        rd("unlisted", 32'h0000_1010, 32'h0);
        rd("ram_w0_kept", 32'h0000_0000, 32'h1111_1111);
        rd("ram_10_kept", 32'h0000_0010, 32'hDEAD_BEEF);
        chk("gpio_kept", {24'b0, gpio_out}, 32'h0000_00A5);

        // W1C on the same edge as a match: set wins
        x = 32'(cyc_m + cyc_ofs) + 32'd6;
        wr(32'h0000_1008, x);
        rd("tcmp_rd", 32'h0000_1008, TEN ? x : 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (32'(cyc_m + cyc_ofs) == x - 32'd1) break;
            @(negedge clk);
            mem_write = 1'b0;
        end
        chk("tie_align", 32'(cyc_m + cyc_ofs), x - 32'd1);
        wr(32'h0000_100C, 32'h1);
        rd("tie_status", 32'h0000_100C, {31'b0, TEN});
        chk("tie_irq", {31'b0, timer_irq}, {31'b0, TEN});
        wr(32'h0000_100C, 32'h0);
        rd("w0_status", 32'h0000_100C, {31'b0, TEN});

        // Asynchronous reset mid-run
        @(negedge clk);
        mem_write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_gpio", {24'b0, gpio_out}, 32'h0);
        chk("mrst_irq", {31'b0, timer_irq}, 32'h0);
        peek("mrst_cycle", 32'h0000_1004, 32'h0);
        peek("mrst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
        peek("mrst_tcmp", 32'h0000_1008, TEN ? 32'hFFFF_FFFF : 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Compare at 20: irq visible from the cycle reading 21
        wr(32'h0000_1008, 32'd20);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            mem_write = 1'b0;
            #1;
            chk("irq_cmp20", {31'b0, timer_irq}, {31'b0, TEN && (cyc_m > 20)});
        end
        rd("tcmp20_rd", 32'h0000_1008, TEN ? 32'd20 : 32'h0);
        wr(32'h0000_100C, 32'h1);
        rd("w1c_status", 32'h0000_100C, 32'h0);
        chk("w1c_irq", {31'b0, timer_irq}, 32'h0);

        // Wrap, including a match at FFFF_FFFF
        wr(32'h0000_1008, 32'hFFFF_FFFF);
        @(negedge clk);
        mem_write = 1'b0;
        force dut.u_timer.cycle_q = 32'hFFFF_FFFD;
        cyc_ofs = 32'hFFFF_FFFD - cyc_m;
        #1;
        release dut.u_timer.cycle_q;
        rd_cyc("wrap_fe");
        rd_cyc("wrap_ff");
        rd_cyc("wrap_00");
        chk("wrap_val", read_data, 32'h0);
        chk("wrap_irq", {31'b0, timer_irq}, {31'b0, TEN});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
